// File: rtl/mrf_nwnr_bypass_pkg.sv
// rtl/mrf_nwnr_bypass_pkg.sv - shared defaults for the N-write/N-read register file
package mrf_nwnr_bypass_pkg;

  localparam int MRF_DW        = 32;
  localparam int MRF_AW        = 5;
  localparam int MRF_NUM_READ  = 2;
  localparam int MRF_NUM_WRITE = 1;

  localparam logic [MRF_DW-1:0] MRF_RST_VAL = '0;

endpackage

// File: rtl/mrf_wr_resolve.sv
// rtl/mrf_wr_resolve.sv - match one address against all write ports, highest index wins
module mrf_wr_resolve
  import mrf_nwnr_bypass_pkg::*;
#(
  parameter int DW        = MRF_DW,
  parameter int AW        = MRF_AW,
  parameter int NUM_WRITE = MRF_NUM_WRITE
) (
  input  logic [NUM_WRITE-1:0]    we,
  input  logic [NUM_WRITE*AW-1:0] waddr,
  input  logic [NUM_WRITE*DW-1:0] wdata,
  input  logic [AW-1:0]           qaddr,
  output logic                    hit,
  output logic [DW-1:0]           data
);

  // Ascending scan: a later (higher) port overrides any earlier match.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (we[j] && (waddr[j*AW +: AW] == qaddr)) begin
        hit  = 1'b1;
        data = wdata[j*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/mrf_nwnr_bypass.sv
// rtl/mrf_nwnr_bypass.sv - multi-port register file with valid bitmap, flash-clear and write bypass
module mrf_nwnr_bypass
  import mrf_nwnr_bypass_pkg::*;
#(
  parameter int             DW        = MRF_DW,
  parameter int             AW        = MRF_AW,
  parameter int             NUM_READ  = MRF_NUM_READ,
  parameter int             NUM_WRITE = MRF_NUM_WRITE,
  parameter bit             BYPASS    = 1'b1,
  parameter bit             ZERO_REG  = 1'b0,
  parameter logic [DW-1:0]  RST_VAL   = DW'(MRF_RST_VAL)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CLR,
  input  logic [NUM_READ-1:0]     RE,
  input  logic [NUM_READ*AW-1:0]  RADDR,
  output logic [NUM_READ*DW-1:0]  RDATA,
  input  logic [NUM_WRITE-1:0]    WE,
  input  logic [NUM_WRITE*AW-1:0] WADDR,
  input  logic [NUM_WRITE*DW-1:0] WDATA
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ent_we;
  logic [DW-1:0]    ent_wd [DEPTH];

  // Per-entry write decode; entry 0 never takes a write when hardwired to zero.
  for (genvar a = 0; a < DEPTH; a++) begin : g_ent
    logic ent_hit;

    mrf_wr_resolve #(
      .DW        (DW),
      .AW        (AW),
      .NUM_WRITE (NUM_WRITE)
    ) u_dec (
      .we    (WE),
      .waddr (WADDR),
      .wdata (WDATA),
      .qaddr (AW'(a)),
      .hit   (ent_hit),
      .data  (ent_wd[a])
    );

    assign ent_we[a] = ent_hit && !(ZERO_REG && (a == 0));
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (ent_we[a]) mem[a] <= ent_wd[a];
      end
    end
  end

  // A write to an entry beats a same-cycle flash-clear of that entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (ent_we[a])  vld[a] <= 1'b1;
        else if (CLR)   vld[a] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
    logic [DW-1:0] rd_next;
    logic [DW-1:0] rd_q;

    assign ra = RADDR[i*AW +: AW];

    mrf_wr_resolve #(
      .DW        (DW),
      .AW        (AW),
      .NUM_WRITE (NUM_WRITE)
    ) u_byp (
      .we    (WE),
      .waddr (WADDR),
      .wdata (WDATA),
      .qaddr (ra),
      .hit   (byp_hit),
      .data  (byp_data)
    );

    always_comb begin
      rd_next = vld[ra] ? mem[ra] : RST_VAL;
      if (BYPASS && byp_hit)  rd_next = byp_data;
      else if (BYPASS && CLR) rd_next = RST_VAL;
      if (ZERO_REG && (ra == '0)) rd_next = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)     rd_q <= RST_VAL;
      else if (RE[i]) rd_q <= rd_next;
    end

    assign RDATA[i*DW +: DW] = rd_q;
  end

endmodule

// File: tb/tb_mrf_nwnr_bypass.sv
// tb/tb_mrf_nwnr_bypass.sv - randomized self-checking bench for two register file configurations
module tb_mrf_nwnr_bypass;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CLR;
  logic [1:0]  RE;
  logic [9:0]  RADDR;
  logic [1:0]  WE;
  logic [9:0]  WADDR;
  logic [63:0] WDATA;
  logic [63:0] rd_a;
  logic [63:0] rd_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model k=0: bypass on, no zero entry. Model k=1: bypass off, entry 0 hardwired to zero.
  logic [31:0] val   [2][32];
  logic [63:0] exp_q [2];

  always #5 CLK = ~CLK;

  mrf_nwnr_bypass #(
    .DW(32), .AW(5), .NUM_READ(2), .NUM_WRITE(2),
    .BYPASS(1'b1), .ZERO_REG(1'b0), .RST_VAL(32'h0)
  ) u_a (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .RE(RE), .RADDR(RADDR), .RDATA(rd_a),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
  );

  mrf_nwnr_bypass #(
    .DW(32), .AW(5), .NUM_READ(2), .NUM_WRITE(2),
    .BYPASS(1'b0), .ZERO_REG(1'b1), .RST_VAL(32'h0)
  ) u_b (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .RE(RE), .RADDR(RADDR), .RDATA(rd_b),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q[k] = 64'h0;
      for (int a = 0; a < 32; a++) val[k][a] = 32'h0;
    end
  endtask

  task automatic step(input logic [1:0] re, input logic [9:0] ra, input logic [1:0] we,
                      input logic [9:0] wa, input logic [63:0] wd, input logic clr);
    logic [4:0]  a;
    logic [31:0] v;
    RE = re; RADDR = ra; WE = we; WADDR = wa; WDATA = wd; CLR = clr;
    if (RST_N) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 2; i++) begin
          if (re[i]) begin
            a = ra[i*5 +: 5];
            v = val[k][a];
            if (k == 0) begin
              if (clr) v = 32'h0;
              for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
            end
            if (k == 1 && a == 5'd0) v = 32'h0;
            exp_q[k][i*32 +: 32] = v;
          end
        end
        if (clr) for (int e = 0; e < 32; e++) val[k][e] = 32'h0;
        for (int j = 0; j < 2; j++)
          if (we[j] && !(k == 1 && wa[j*5 +: 5] == 5'd0)) val[k][wa[j*5 +: 5]] = wd[j*32 +: 32];
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CLR = 1'b0; RE = '0; RADDR = '0; WE = '0; WADDR = '0; WDATA = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_state a=%h b=%h want 0", rd_a, rd_b);
    end
    RST_N = 1'b1;
    for (int a = 0; a < 32; a++) begin
      step(2'b11, {5'(31 - a), 5'(a)}, 2'b00, 10'h0, 64'h0, 1'b0);
      vectors++;
      if (rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d a=%h/%h b=%h/%h", a, rd_a, exp_q[0], rd_b, exp_q[1]);
      end
    end
  endtask

  task automatic test_write_read();
    step(2'b00, 10'h0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0);
    step(2'b10, {5'd5, 5'd0}, 2'b00, 10'h0, 64'h0, 1'b0);
    vectors++;
    if (rd_a[63:32] !== 32'hDEADBEEF || rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL write_read a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
    for (int c = 0; c < 10; c++) begin
      step(2'b00, 10'($urandom), 2'b01, {5'd0, 5'd5}, {32'h0, $urandom}, c[0]);
      vectors++;
      if (rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
        miscompares++;
        $display("FAIL hold cyc=%0d a=%h/%h b=%h/%h", c, rd_a, exp_q[0], rd_b, exp_q[1]);
      end
    end
  endtask

  task automatic test_bypass();
    step(2'b00, 10'h0, 2'b01, {5'd0, 5'd7}, {32'h0, 32'hA5A5A5A5}, 1'b0);
    step(2'b01, {5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h12345678}, 1'b0);
    vectors++;
    if (rd_a[31:0] !== 32'h12345678 || rd_b[31:0] !== 32'hA5A5A5A5 ||
        rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL bypass a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
    step(2'b11, {5'd7, 5'd7}, 2'b00, 10'h0, 64'h0, 1'b1);
    vectors++;
    if (rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL bypass_clr a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
  endtask

  task automatic test_waw();
    step(2'b01, {5'd0, 5'd3}, 2'b11, {5'd3, 5'd3}, {32'h22, 32'h11}, 1'b0);
    vectors++;
    if (rd_a[31:0] !== 32'h22 || rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL waw_bypass a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
    step(2'b11, {5'd3, 5'd3}, 2'b00, 10'h0, 64'h0, 1'b0);
    vectors++;
    if (rd_b !== {32'h22, 32'h22} || rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL waw_read a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
  endtask

  task automatic test_clear();
    step(2'b00, 10'h0, 2'b11, {5'd2, 5'd1}, {$urandom, $urandom}, 1'b0);
    step(2'b00, 10'h0, 2'b11, {5'd4, 5'd3}, {$urandom, $urandom}, 1'b0);
    step(2'b00, 10'h0, 2'b10, {5'd2, 5'd0}, {32'h99, 32'h0}, 1'b1);
    for (int p = 0; p < 2; p++) begin
      step(2'b11, {5'(2 + 2 * p), 5'(1 + 2 * p)}, 2'b00, 10'h0, 64'h0, 1'b0);
      vectors++;
      if (rd_a !== (p == 0 ? {32'h99, 32'h0} : 64'h0) || rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
        miscompares++;
        $display("FAIL clear pair=%0d a=%h/%h b=%h/%h", p, rd_a, exp_q[0], rd_b, exp_q[1]);
      end
    end
  endtask

  task automatic test_zero_reg();
    step(2'b01, {5'd0, 5'd0}, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 1'b0);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (rd_b[31:0] !== 32'h0 || rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
        miscompares++;
        $display("FAIL zero_reg cyc=%0d a=%h/%h b=%h/%h", c, rd_a, exp_q[0], rd_b, exp_q[1]);
      end
      step(2'b11, {5'd0, 5'd0}, 2'b00, 10'h0, 64'h0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    step(2'b00, 10'h0, 2'b01, {5'd0, 5'd9}, {32'h0, 32'hCAFE0001}, 1'b0);
    step(2'b11, {5'd9, 5'd9}, 2'b00, 10'h0, 64'h0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      miscompares++;
      $display("FAIL async_reset a=%h b=%h want 0", rd_a, rd_b);
    end
    step(2'b11, {5'd9, 5'd9}, 2'b11, {5'd9, 5'd9}, {$urandom, $urandom}, 1'b0);
    vectors++;
    if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_ignores_ops a=%h b=%h want 0", rd_a, rd_b);
    end
    RST_N = 1'b1;
    step(2'b11, {5'd9, 5'd9}, 2'b00, 10'h0, 64'h0, 1'b0);
    vectors++;
    if (rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
      miscompares++;
      $display("FAIL post_reset_read a=%h/%h b=%h/%h", rd_a, exp_q[0], rd_b, exp_q[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
           2'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
           {$urandom, $urandom}, ($urandom_range(0, 15) == 0));
      vectors++;
      if (rd_a !== exp_q[0] || rd_b !== exp_q[1]) begin
        miscompares++;
        $display("FAIL random cyc=%0d a=%h/%h b=%h/%h", c, rd_a, exp_q[0], rd_b, exp_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_waw();
    test_clear();
    test_zero_reg();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mrf_nwnr_bypass.md
Name: mrf_nwnr_bypass

Overview:
- Parametrised multi-write, multi-read register file with registered read ports. Next generation of the team's N-write/N-read RF.
- Adds asynchronous reset via a per-entry valid bitmap, plus a one-cycle flash-clear.
- Adds optional write-to-read bypass, deterministic write-after-write priority, and an optional hardwired-zero entry 0.
- Used as the CPU integer regfile and as a generic small table in the cache and TLB control.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width in bits; depth is 2**AW.
- NUM_READ, 2, number of read ports.
- NUM_WRITE, 1, number of write ports.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read port; 0 = the read returns pre-write contents.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded.
- RST_VAL, 0, DW-bit value returned for any entry whose valid bit is clear.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous flash-clear of all valid bits.
- RE  in  NUM_READ  per-port read enable.
- RADDR  in  NUM_READ*AW  read addresses; port i uses bits [i*AW +: AW].
- RDATA  out  NUM_READ*DW  registered read data; port i uses bits [i*DW +: DW].
- WE  in  NUM_WRITE  per-port write enable.
- WADDR  in  NUM_WRITE*AW  write addresses.
- WDATA  in  NUM_WRITE*DW  write data.

Behaviour:
- Storage:
  - Data array of 2**AW x DW, no reset.
  - Valid bitmap vld[2**AW-1:0], reset asynchronously.
  - Entry effective value = vld[a] ? array[a] : RST_VAL.
- Reset (RST_N=0), asynchronous:
  - vld cleared to all 0.
  - Every RDATA port register set to RST_VAL immediately.
  - Writes and reads are ignored while RST_N=0.
  - Deassertion mid-operation: the first edge with RST_N=1 operates normally.
- Write, at the edge:
  - For each j with WE[j]=1: array[WADDR_j] <= WDATA_j and vld[WADDR_j] <= 1.
  - WAW conflict (same address, several WE): the highest port index j wins for both data and valid.
  - ZERO_REG=1: writes to address 0 are dropped and vld[0] is never set.
- Flash-clear: CLR=1 at an edge sets vld <= 0 for all entries, except entries written in the same cycle. A write wins over CLR.
- Read, latency 1 cycle:
  - RE[i]=1 at edge k: RDATA_i after edge k equals the effective value of RADDR_i.
  - RE[i]=0: RDATA_i holds its previous value indefinitely.
- Bypass, when RE[i]=1 and some WE[j] targets RADDR_i in the same cycle:
  - BYPASS=1: RDATA_i = WDATA of the winning (highest) j.
  - BYPASS=0: RDATA_i = the pre-edge effective value.
  - CLR in the same cycle with no matching write: BYPASS=1 returns RST_VAL; BYPASS=0 returns the pre-edge value.
- ZERO_REG=1 with RADDR_i=0: RDATA_i = 0, overriding bypass and RST_VAL.
- Multiple read ports may read the same address and receive identical data.
- No X propagation: unwritten entries always read RST_VAL.
- Simulation only: the data array is randomised at time 0, which the valid bitmap must mask.

Decomposition:
- Shared package holds:
  - Default widths (DW, AW).
  - Port-count defaults.
  - An RST_VAL default constant.
- One natural sub-module, mrf_wr_resolve:
  - Inputs: WE, WADDR, WDATA, and one query address.
  - Outputs: hit and winning data, using highest-index priority.
- mrf_wr_resolve is instantiated once per read port for bypass, and reused for per-entry write-enable decode.

Test Plan:
- Reset, then read addresses 0..31 on both ports with RST_VAL=0 -> RDATA = 0 for every address, with a random array underneath. Pulse RST_N low mid-read -> RDATA goes to 0 without waiting for a clock edge.
- Write 0xDEADBEEF to addr 5, next cycle read addr 5 on port 1 -> RDATA_1 = 0xDEADBEEF one cycle after RE. Drop RE -> value held for 10 cycles.
- BYPASS=1: write 0x12345678 to addr 7 and read addr 7 in the same cycle -> RDATA = 0x12345678. Repeat with BYPASS=0 and a prior value 0xA5A5A5A5 -> RDATA = 0xA5A5A5A5.
- NUM_WRITE=2: both ports write addr 3 (0x11 on port 0, 0x22 on port 1) -> later read returns 0x22; bypass read in the same cycle also returns 0x22.
- Fill addrs 1..4, then assert CLR together with a write of 0x99 to addr 2 -> reads give addr 1/3/4 = RST_VAL and addr 2 = 0x99.
- ZERO_REG=1: write 0xFFFF_FFFF to addr 0 with a same-cycle read of addr 0 -> RDATA = 0 then and in all later reads.
